// File: rtl/seg_p2s_shifter.sv
// Parallel-to-serial shifter for the display word.
// Clocks the word MSB-first into a serial chain, then strobes the latch.
module seg_p2s_shifter #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_data,
  output logic              s_latch
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign s_data  = shreg[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_latch <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          s_clk   <= 1'b0;
          s_latch <= 1'b0;
          if (start) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!s_clk) begin
              s_clk <= 1'b1;
            end else begin
              // end of high phase: advance to the next bit
              s_clk   <= 1'b0;
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                s_latch <= 1'b1;
                state   <= LATCH;
              end
            end
          end
        end
        LATCH: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            s_latch <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Scoreboard bench for seg_p2s_shifter.
// Driver pushes expected bits/words/done cycles; monitors pop and compare.
module tb_seg_p2s_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [63:0] din_a, din_b;
  logic        busy_a, done_a, s_clk_a, s_data_a, s_latch_a;
  logic        busy_b, done_b, s_clk_b, s_data_b, s_latch_b;

  seg_p2s_shifter #(.DATA_W(64), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(din_a),
    .busy(busy_a), .done(done_a), .s_clk(s_clk_a),
    .s_data(s_data_a), .s_latch(s_latch_a)
  );

  seg_p2s_shifter #(.DATA_W(64), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(din_b),
    .busy(busy_b), .done(done_b), .s_clk(s_clk_b),
    .s_data(s_data_b), .s_latch(s_latch_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit          exp_bits[$];
  logic [63:0] exp_word[$];
  int          exp_done[$];
  int          db[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s act=event req=none", nm);
  endtask

  // monitor for the CLK_DIV=2 instance
  logic        pclk_a = 1'b0;
  logic        plat_a = 1'b0;
  logic [63:0] msr = '0;
  int          llen = 0;

  always @(negedge clk) begin
    if (s_clk_a === 1'b1 && pclk_a === 1'b0) begin
      msr = {msr[62:0], s_data_a};
      if (exp_bits.size() == 0) unexpected("bit_unexpected");
      else chk("bit", 64'(s_data_a), 64'(exp_bits.pop_front()));
    end
    if (s_latch_a === 1'b1 && plat_a === 1'b0) begin
      llen = 0;
      if (exp_word.size() == 0) unexpected("latch_unexpected");
      else chk("word_at_latch", msr, exp_word.pop_front());
    end
    if (s_latch_a === 1'b1) llen++;
    if (s_latch_a === 1'b0 && plat_a === 1'b1)
      chk("latch_len", 64'(llen), 64'd2);
    if (done_a === 1'b1) begin
      if (exp_done.size() == 0) unexpected("done_unexpected");
      else chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      chk("busy_at_done", 64'(busy_a), 64'd0);
    end
    pclk_a = s_clk_a;
    plat_a = s_latch_a;
  end

  // monitor for the CLK_DIV=1 instance
  logic pclk_b = 1'b0;
  int   last_rise = 0;
  int   nb_rise = 0;

  always @(negedge clk) begin
    if (s_clk_b === 1'b1 && pclk_b === 1'b0) begin
      if (nb_rise > 0)
        chk("sclk_period", 64'(cyc - last_rise), 64'd2);
      last_rise = cyc;
      nb_rise++;
    end
    if (done_b === 1'b1) begin
      db.push_back(cyc);
      nb_rise = 0;
    end
    pclk_b = s_clk_b;
  end

  task automatic send(input logic [63:0] w, input int nbits,
                      input bit full, output int t0);
    @(negedge clk);
    din_a   = w;
    start_a = 1'b1;
    t0      = cyc;
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[63-i]);
    if (full) begin
      exp_word.push_back(w);
      exp_done.push_back(t0 + 259);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      unexpected(nm);
      exp_done.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int n;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    din_a   = '0;
    din_b   = 64'hA5A5_5A5A_C3C3_3C3C;
    repeat (3) @(negedge clk);
    chk("rst_busy",    64'(busy_a),    64'd0);
    chk("rst_done",    64'(done_a),    64'd0);
    chk("rst_sclk",    64'(s_clk_a),   64'd0);
    chk("rst_slatch",  64'(s_latch_a), 64'd0);
    chk("rst_sdata",   64'(s_data_a),  64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(64'h8000_0000_0000_0001, 64, 1'b1, t0);
    chk("busy_after_start", 64'(busy_a), 64'd1);
    wait_done_a("timeout_t2");

    send(64'hDEAD_BEEF_0123_4567, 64, 1'b1, t0);
    repeat (48) @(negedge clk);
    din_a   = 64'h1111_2222_3333_4444;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    din_a   = '0;
    wait_done_a("timeout_t3");

    send(64'hF0F0_1234_0F0F_ABCD, 25, 1'b0, t0);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   64'(busy_a),    64'd0);
    chk("abort_done",   64'(done_a),    64'd0);
    chk("abort_sclk",   64'(s_clk_a),   64'd0);
    chk("abort_slatch", 64'(s_latch_a), 64'd0);
    chk("abort_sdata",  64'(s_data_a),  64'd0);
    repeat (300) @(negedge clk);
    chk("abort_bits_left", 64'(exp_bits.size()), 64'd0);

    start_b = 1'b1;
    n = 0;
    while (db.size() < 3 && n < 600) begin
      @(negedge clk);
      n++;
    end
    start_b = 1'b0;
    if (db.size() < 3) begin
      unexpected("timeout_t6");
    end else begin
      chk("done_gap_1", 64'(db[1] - db[0]), 64'd131);
      chk("done_gap_2", 64'(db[2] - db[1]), 64'd131);
    end
    repeat (5) @(negedge clk);

    chk("bits_left",  64'(exp_bits.size()), 64'd0);
    chk("words_left", 64'(exp_word.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
